// File: rtl/rename_pkg.sv
// Shared types and configuration for the register-renaming core.
// NUM_AREGS, NUM_TAGS and NUM_CDB live here so that the interface, the free
// list, the top level and any bench all see one consistent configuration.
package rename_pkg;

  localparam int NUM_AREGS = 32;  // register 0 is never renamed
  localparam int NUM_TAGS  = 64;  // power of 2, >= 2
  localparam int NUM_CDB   = 2;   // >= 1

  localparam int AREG_W = $clog2(NUM_AREGS);
  localparam int TAG_W  = $clog2(NUM_TAGS);
  localparam int SEL_W  = $clog2(NUM_CDB) + 1;

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [TAG_W:0]    count_t;
  typedef logic [SEL_W-1:0]  sel_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } rst_entry_t;

  // Extract the tag carried by CDB channel k from the flattened bus.
  function automatic tag_t cdb_tag_at(input logic [NUM_CDB*TAG_W-1:0] tags, input int k);
    return tags[k*TAG_W +: TAG_W];
  endfunction

endpackage

// File: rtl/rename_if.sv
// Dispatch, CDB and register-file-write signals of the rename unit.
// master: decoder/CDB side; slave: the rename unit itself.
interface rename_if;
  import rename_pkg::*;

  logic                       flush;
  logic                       dpch_valid;
  logic                       dpch_ready;
  areg_t                      dpch_rs1;
  areg_t                      dpch_rs2;
  areg_t                      dpch_rd;
  logic                       dpch_rd_we;

  tag_t                       rs1_tag;
  logic                       rs1_tag_valid;
  logic                       rs1_fw_valid;
  sel_t                       rs1_fw_sel;
  tag_t                       rs2_tag;
  logic                       rs2_tag_valid;
  logic                       rs2_fw_valid;
  sel_t                       rs2_fw_sel;

  tag_t                       rd_tag;
  logic                       rd_tag_valid;

  logic [NUM_CDB-1:0]         cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
  logic [NUM_CDB-1:0]         rf_we;
  logic [NUM_CDB*AREG_W-1:0]  rf_rd;
  count_t                     free_count;

  modport master (
    output flush, dpch_valid, dpch_rs1, dpch_rs2, dpch_rd, dpch_rd_we, cdb_valid, cdb_tag,
    input  dpch_ready, rs1_tag, rs1_tag_valid, rs1_fw_valid, rs1_fw_sel,
           rs2_tag, rs2_tag_valid, rs2_fw_valid, rs2_fw_sel,
           rd_tag, rd_tag_valid, rf_we, rf_rd, free_count
  );

  modport slave (
    input  flush, dpch_valid, dpch_rs1, dpch_rs2, dpch_rd, dpch_rd_we, cdb_valid, cdb_tag,
    output dpch_ready, rs1_tag, rs1_tag_valid, rs1_fw_valid, rs1_fw_sel,
           rs2_tag, rs2_tag_valid, rs2_fw_valid, rs2_fw_sel,
           rd_tag, rd_tag_valid, rf_we, rf_rd, free_count
  );

endinterface

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical tags: NUM_CDB push ports (channel 0 first),
// one pop port. Reset and flush refill it with tags 0..NUM_TAGS-1 in order.
// A tag pushed in a cycle is only visible at the head from the next cycle.
module rename_free_list
  import rename_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_CDB-1:0]       push_valid,
  input  logic [NUM_CDB*TAG_W-1:0] push_tag,
  input  logic                     pop,
  output tag_t                     head,
  output count_t                   count
);

  tag_t   mem [NUM_TAGS];
  tag_t   head_ptr;
  tag_t   tail_ptr;
  count_t count_q;
  tag_t   slot [NUM_CDB];
  tag_t   tail_next;
  count_t push_cnt;

  // Give each pushing channel its own consecutive slot behind the tail
  // NOTE: blocking '=' is correct in combinational logic: tail_next must
  // accumulate channel by channel within one evaluation; flops use '<='.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    tail_next = tail_ptr;
    push_cnt  = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      slot[k] = tail_next;
      if (push_valid[k]) begin
        tail_next = tail_next + tag_t'(1);
        push_cnt  = push_cnt + count_t'(1);
      end
    end
  end

  // FIFO storage, pointers and occupancy; pointers wrap modulo NUM_TAGS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= count_t'(NUM_TAGS);
      // NOTE: this storage is reset on purpose: its reset content is the
      // initial free list, not don't-care data.
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= tag_t'(i);
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= count_t'(NUM_TAGS);
      for (int i = 0; i < NUM_TAGS; i++) mem[i] <= tag_t'(i);
    end else begin
      assert (int'(count_q) + int'(push_cnt) - int'(pop) <= NUM_TAGS);
      assert (!(pop && count_q == '0));
      for (int k = 0; k < NUM_CDB; k++) begin
        if (push_valid[k]) mem[slot[k]] <= cdb_tag_at(push_tag, k);
      end
      tail_ptr <= tail_next;
      if (pop) head_ptr <= head_ptr + tag_t'(1);
      count_q <= count_q + push_cnt - count_t'(pop);
    end
  end

  assign head  = mem[head_ptr];
  assign count = count_q;

endmodule

// File: rtl/rename_unit.sv
// Register-renaming core: register status table (RST), CDB retire/forward
// matching and the dispatch handshake around a tag free list.
// Optional feature: define RENAME_STALL_CNT_EN to add the 32-bit saturating
// stall_cnt output (cycles with dpch_valid & ~dpch_ready, cleared by rst only).
module rename_unit
  import rename_pkg::*;
(
  input logic      clk,
  input logic      rst,
  rename_if.slave  bus
`ifdef RENAME_STALL_CNT_EN
  , output logic [31:0] stall_cnt
`endif
);

  rst_entry_t         rst_tab [NUM_AREGS];
  tag_t               head;
  count_t             count;
  logic               need_tag;
  logic               ready;
  logic               alloc;
  logic               pop;
  logic [NUM_CDB-1:0] hit;
  areg_t              hit_r [NUM_CDB];
  rst_entry_t         rs1_e;
  rst_entry_t         rs2_e;
  logic               rs1_pend;
  logic               rs2_pend;
  logic [SEL_W:0]     fw1;
  logic [SEL_W:0]     fw2;

  // {hit, lowest matching channel} for a tag against this cycle's CDB
  function automatic logic [SEL_W:0] fw_lookup(input tag_t t,
                                               input logic [NUM_CDB-1:0] v,
                                               input logic [NUM_CDB*TAG_W-1:0] tags);
    logic found;
    sel_t sel;
    found = 1'b0;
    sel   = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (v[k] && cdb_tag_at(tags, k) == t) begin
        found = 1'b1;
        sel   = sel_t'(k);
      end
    end
    return {found, sel};
  endfunction

  rename_free_list u_free_list (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .push_valid (bus.cdb_valid),
    .push_tag   (bus.cdb_tag),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  // Dispatch handshake; readiness depends only on the registered free count
  always_comb begin
    need_tag         = bus.dpch_rd_we & (bus.dpch_rd != '0);
    ready            = ~need_tag | (count != '0);
    alloc            = bus.dpch_valid & ready & need_tag;
    pop              = alloc & ~bus.flush;
    bus.dpch_ready   = ready;
    bus.rd_tag       = head;
    bus.rd_tag_valid = alloc;
    bus.free_count   = count;
  end

  // Retire matching: find the RST entry still waiting on each broadcast tag
  always_comb begin
    bus.rf_rd = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      hit[k]   = 1'b0;
      hit_r[k] = '0;
      for (int r = NUM_AREGS - 1; r >= 1; r--) begin
        if (bus.cdb_valid[k] && rst_tab[r].valid && rst_tab[r].tag == cdb_tag_at(bus.cdb_tag, k)) begin
          hit[k]   = 1'b1;
          hit_r[k] = areg_t'(r);
        end
      end
      bus.rf_rd[k*AREG_W +: AREG_W] = hit_r[k];
    end
    bus.rf_we = hit;
  end

  // Source lookups see the mapping before this instruction's own rename
  always_comb begin
    rs1_e             = rst_tab[bus.dpch_rs1];
    rs2_e             = rst_tab[bus.dpch_rs2];
    rs1_pend          = (bus.dpch_rs1 != '0) & rs1_e.valid;
    rs2_pend          = (bus.dpch_rs2 != '0) & rs2_e.valid;
    fw1               = fw_lookup(rs1_e.tag, bus.cdb_valid, bus.cdb_tag);
    fw2               = fw_lookup(rs2_e.tag, bus.cdb_valid, bus.cdb_tag);
    bus.rs1_tag       = rs1_e.tag;
    bus.rs1_tag_valid = rs1_pend;
    bus.rs1_fw_valid  = rs1_pend & fw1[SEL_W];
    bus.rs1_fw_sel    = (rs1_pend & fw1[SEL_W]) ? fw1[SEL_W-1:0] : '0;
    bus.rs2_tag       = rs2_e.tag;
    bus.rs2_tag_valid = rs2_pend;
    bus.rs2_fw_valid  = rs2_pend & fw2[SEL_W];
    bus.rs2_fw_sel    = (rs2_pend & fw2[SEL_W]) ? fw2[SEL_W-1:0] : '0;
  end

  // RST update: retires clear first, a same-cycle rename of rd then wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_AREGS; r++) rst_tab[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_CDB; j++) begin
        for (int k = j + 1; k < NUM_CDB; k++) begin
          assert (!(bus.cdb_valid[j] && bus.cdb_valid[k] &&
                    cdb_tag_at(bus.cdb_tag, j) == cdb_tag_at(bus.cdb_tag, k)));
        end
      end
      if (bus.flush) begin
        for (int r = 0; r < NUM_AREGS; r++) rst_tab[r].valid <= 1'b0;
      end else begin
        for (int k = 0; k < NUM_CDB; k++) begin
          if (hit[k]) rst_tab[hit_r[k]].valid <= 1'b0;
        end
        if (alloc) rst_tab[bus.dpch_rd] <= '{valid: 1'b1, tag: head};
      end
    end
  end

`ifdef RENAME_STALL_CNT_EN
  // Saturating count of cycles where the decoder is held off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (bus.dpch_valid && !ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: directed scenarios followed by random
// traffic, all compared against a map + free-queue reference model.
module tb_rename_unit;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_if bus_i ();
`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt;
  longint      m_stall;
`endif

  rename_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
`ifdef RENAME_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: architectural map, free queue and in-flight tag list
  bit m_valid [NUM_AREGS];
  int m_tag   [NUM_AREGS];
  int free_q  [$];
  int fly     [$];

  // Stimulus for the next cycle
  bit s_valid, s_we, s_flush;
  int s_rs1, s_rs2, s_rd;
  bit s_cdb_v [NUM_CDB];
  int s_cdb_t [NUM_CDB];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NUM_AREGS; r++) m_valid[r] = 1'b0;
    free_q.delete();
    for (int i = 0; i < NUM_TAGS; i++) free_q.push_back(i);
    fly.delete();
  endfunction

  task automatic idle();
    s_valid = 0; s_we = 0; s_flush = 0;
    s_rs1 = 0; s_rs2 = 0; s_rd = 0;
    for (int k = 0; k < NUM_CDB; k++) begin
      s_cdb_v[k] = 0;
      s_cdb_t[k] = 0;
    end
  endtask

  task automatic check_src(input string nm, input int rs, input logic [31:0] tag,
                           input logic [31:0] tv, input logic [31:0] fv, input logic [31:0] sel);
    bit exp_tv, exp_fv;
    int exp_sel;
    exp_tv  = (rs != 0) && m_valid[rs];
    exp_fv  = 0;
    exp_sel = 0;
    check({nm, "_tag_valid"}, tv, 32'(exp_tv));
    if (exp_tv) begin
      check({nm, "_tag"}, tag, m_tag[rs]);
      for (int k = 0; k < NUM_CDB; k++) begin
        if (!exp_fv && s_cdb_v[k] && s_cdb_t[k] == m_tag[rs]) begin
          exp_fv  = 1;
          exp_sel = k;
        end
      end
    end
    check({nm, "_fw_valid"}, fv, 32'(exp_fv));
    if (exp_fv) check({nm, "_fw_sel"}, sel, exp_sel);
  endtask

  // Drive one cycle at the falling edge, check just after, then advance model
  task automatic step();
    logic [NUM_CDB*TAG_W-1:0] tv;
    logic [NUM_CDB-1:0]       cv;
    bit need, ready, alloc;
    bit mh [NUM_CDB];
    int mr [NUM_CDB];
    int t;
    @(negedge clk);
    tv = '0;
    cv = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      tv[k*TAG_W +: TAG_W] = tag_t'(s_cdb_t[k]);
      cv[k] = s_cdb_v[k];
    end
    bus_i.dpch_valid = s_valid;
    bus_i.dpch_rd_we = s_we;
    bus_i.dpch_rd    = areg_t'(s_rd);
    bus_i.dpch_rs1   = areg_t'(s_rs1);
    bus_i.dpch_rs2   = areg_t'(s_rs2);
    bus_i.cdb_valid  = cv;
    bus_i.cdb_tag    = tv;
    bus_i.flush      = s_flush;
    #1;
    need  = s_we && (s_rd != 0);
    ready = !need || (free_q.size() != 0);
    alloc = s_valid && ready && need;
    check("dpch_ready", 32'(bus_i.dpch_ready), 32'(ready));
    check("rd_tag_valid", 32'(bus_i.rd_tag_valid), 32'(alloc));
    if (alloc) check("rd_tag", 32'(bus_i.rd_tag), free_q[0]);
    check("free_count", 32'(bus_i.free_count), free_q.size());
    check_src("rs1", s_rs1, 32'(bus_i.rs1_tag), 32'(bus_i.rs1_tag_valid),
              32'(bus_i.rs1_fw_valid), 32'(bus_i.rs1_fw_sel));
    check_src("rs2", s_rs2, 32'(bus_i.rs2_tag), 32'(bus_i.rs2_tag_valid),
              32'(bus_i.rs2_fw_valid), 32'(bus_i.rs2_fw_sel));
    for (int k = 0; k < NUM_CDB; k++) begin
      mh[k] = 0;
      mr[k] = 0;
      if (s_cdb_v[k]) begin
        for (int r = 1; r < NUM_AREGS; r++) begin
          if (m_valid[r] && m_tag[r] == s_cdb_t[k]) begin
            mh[k] = 1;
            mr[k] = r;
          end
        end
      end
      check("rf_we", 32'(bus_i.rf_we[k]), 32'(mh[k]));
      if (mh[k]) check("rf_rd", 32'(bus_i.rf_rd[k*AREG_W +: AREG_W]), mr[k]);
    end
`ifdef RENAME_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'(m_stall));
    if (s_valid && !ready) m_stall++;
`endif
    if (s_flush) begin
      model_reset();
    end else begin
      if (alloc) t = free_q.pop_front();
      for (int k = 0; k < NUM_CDB; k++) begin
        if (s_cdb_v[k]) begin
          int idx [$];
          if (mh[k]) m_valid[mr[k]] = 0;
          idx = fly.find_first_index(x) with (x == s_cdb_t[k]);
          if (idx.size() != 0) fly.delete(idx[0]);
          free_q.push_back(s_cdb_t[k]);
        end
      end
      if (alloc) begin
        m_valid[s_rd] = 1;
        m_tag[s_rd]   = t;
        fly.push_back(t);
      end
    end
  endtask

  task automatic dispatch(input int rd);
    idle();
    s_valid = 1; s_we = 1; s_rd = rd;
    step();
  endtask

  task automatic do_flush();
    idle();
    s_flush = 1;
    step();
  endtask

  initial begin
    int i0, i1, rp;
    idle();
    model_reset();
`ifdef RENAME_STALL_CNT_EN
    m_stall = 0;
`endif
    bus_i.flush = 0; bus_i.dpch_valid = 0; bus_i.dpch_rd_we = 0;
    bus_i.dpch_rd = '0; bus_i.dpch_rs1 = '0; bus_i.dpch_rs2 = '0;
    bus_i.cdb_valid = '0; bus_i.cdb_tag = '0;
    rst = 1'b0;
    #12;
    check("rst_free_count", 32'(bus_i.free_count), NUM_TAGS);
    check("rst_ready", 32'(bus_i.dpch_ready), 1);
    check("rst_rf_we", 32'(bus_i.rf_we), 0);
    check("rst_rd_tag_valid", 32'(bus_i.rd_tag_valid), 0);
    rst = 1'b1;

    // First rename takes tag 0; the next lookup sees it pending
    dispatch(5);
    check("t1_rd_tag", 32'(bus_i.rd_tag), 0);
    idle(); s_rs1 = 5; step();
    check("t1_rs1_tag", 32'(bus_i.rs1_tag), 0);
    check("t1_rs1_tag_valid", 32'(bus_i.rs1_tag_valid), 1);
    check("t1_free_count", 32'(bus_i.free_count), NUM_TAGS - 1);

    // Exhaust the free list, then recover with one retire
    do_flush();
    for (int i = 0; i < NUM_TAGS; i++) dispatch((i % (NUM_AREGS - 1)) + 1);
    dispatch(3);
    check("t2_ready_empty", 32'(bus_i.dpch_ready), 0);
    check("t2_free_zero", 32'(bus_i.free_count), 0);
    idle(); s_valid = 1; s_rd = 3; step();
    check("t2_ready_no_we", 32'(bus_i.dpch_ready), 1);
    idle(); s_cdb_v[0] = 1; s_cdb_t[0] = 10; step();
    dispatch(3);
    check("t2_ready_after_retire", 32'(bus_i.dpch_ready), 1);
    check("t2_recycled_tag", 32'(bus_i.rd_tag), 10);

    // Dual retire in one cycle
    do_flush();
    dispatch(5);
    dispatch(6);
    idle(); s_cdb_v[0] = 1; s_cdb_t[0] = 0; s_cdb_v[1] = 1; s_cdb_t[1] = 1; step();
    check("t3_rf_we", 32'(bus_i.rf_we), 3);
    check("t3_rf_rd", 32'(bus_i.rf_rd), (6 << AREG_W) | 5);
    idle(); s_rs1 = 5; s_rs2 = 6; step();
    check("t3_free_count", 32'(bus_i.free_count), NUM_TAGS);

    // Forward from channel 1
    dispatch(8);
    dispatch(7);
    idle(); s_rs2 = 7; s_cdb_v[1] = 1; s_cdb_t[1] = 3; step();
    check("t4_fw_valid", 32'(bus_i.rs2_fw_valid), 1);
    check("t4_fw_sel", 32'(bus_i.rs2_fw_sel), 1);

    // Retire of a re-renamed register's old tag
    do_flush();
    dispatch(5);
    dispatch(5);
    idle(); s_cdb_v[0] = 1; s_cdb_t[0] = 0; step();
    check("t5_rf_we", 32'(bus_i.rf_we), 0);
    idle(); s_rs1 = 5; step();
    check("t5_rs1_tag", 32'(bus_i.rs1_tag), 1);

    // Rename and retire of the old tag together; then flush; then rd=0
    do_flush();
    dispatch(9);
    dispatch(4);
    idle(); s_valid = 1; s_we = 1; s_rd = 9; s_cdb_v[0] = 1; s_cdb_t[0] = 0; step();
    check("t6_rf_we", 32'(bus_i.rf_we), 1);
    idle(); s_rs1 = 9; step();
    check("t6_rs1_tag", 32'(bus_i.rs1_tag), 2);
    idle(); s_valid = 1; s_we = 1; s_rd = 12; s_cdb_v[0] = 1; s_cdb_t[0] = 1; s_flush = 1; step();
    idle(); s_rs1 = 9; s_rs2 = 4; step();
    check("t6_flush_rs1", 32'(bus_i.rs1_tag_valid), 0);
    check("t6_flush_free", 32'(bus_i.free_count), NUM_TAGS);
    dispatch(0);
    check("t6_rd0_valid", 32'(bus_i.rd_tag_valid), 0);

    // Random traffic: retire-light first to reach an empty list, then balanced
    for (int n = 0; n < 3000; n++) begin
      idle();
      rp      = (n < 1000) ? 3 : 1;
      s_valid = ($urandom_range(0, 3) != 0);
      s_we    = ($urandom_range(0, 4) != 0);
      s_rd    = $urandom_range(0, NUM_AREGS - 1);
      s_rs1   = $urandom_range(0, NUM_AREGS - 1);
      s_rs2   = $urandom_range(0, NUM_AREGS - 1);
      s_flush = ($urandom_range(0, 199) == 0);
      i0 = -1;
      if (fly.size() > 0 && $urandom_range(0, rp) == 0) begin
        i0 = $urandom_range(0, fly.size() - 1);
        s_cdb_v[0] = 1;
        s_cdb_t[0] = fly[i0];
      end
      if (NUM_CDB > 1 && fly.size() > 1 && $urandom_range(0, rp) == 0) begin
        i1 = $urandom_range(0, fly.size() - 1);
        if (i1 == i0) i1 = (i1 + 1) % fly.size();
        s_cdb_v[NUM_CDB-1] = 1;
        s_cdb_t[NUM_CDB-1] = fly[i1];
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
